// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory loader.
package imem_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    // Even-parity bit: makes the total count of ones in {par, word} even.
    function automatic logic even_par(input logic [INSTR_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-write, single-synchronous-read instruction storage.
// The array itself is never reset; only the read register is.
module imem_ram #(
    parameter int DEPTH = 1024,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader and a 1-cycle fetch port.
// Optional per-word even parity with a par_err output: define IMEM_PARITY_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ready,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               fetch_fault,
`ifdef IMEM_PARITY_EN
    output logic               par_err,
`endif
    input  logic               ld_start,
    input  logic [CNT_W-1:0]   ld_count,
    input  logic               ld_byte_valid,
    input  logic [7:0]         ld_byte,
    output logic               ld_busy,
    output logic               ld_done
);

    localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int DW = INSTR_W + 1;
`else
    localparam int DW = INSTR_W;
`endif

    // ---------------- fetch path ----------------
    logic              accept, bad_addr, rd_en;
    logic [ADDR_W-3:0] word_idx;
    logic              valid_d, valid_q;
    logic              fault_d, fault_q;
    logic [DW-1:0]     rdata;

    logic              busy_d, busy_q;
    logic              done_d, done_q;

    assign word_idx = fetch_addr[ADDR_W-1:2];
    assign accept   = fetch_req && !busy_q;
    assign bad_addr = (fetch_addr[1:0] != 2'b00) || (word_idx >= (ADDR_W-2)'(DEPTH));
    assign rd_en    = accept && !bad_addr;

    always_comb begin
        valid_d = accept;
        fault_d = accept && bad_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign fetch_ready = !busy_q;
    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q;
    // The read register resets to zero, so fetch_instr is zero out of reset.
    assign fetch_instr = fault_q ? NOP_INSTR : rdata[INSTR_W-1:0];

`ifdef IMEM_PARITY_EN
    assign par_err = valid_q && !fault_q && (^rdata);
`endif

    // ---------------- load FSM ----------------
    ld_state_e          st_d, st_q;
    logic [CNT_W-1:0]   ptr_d, ptr_q;
    logic [CNT_W-1:0]   limit_d, limit_q;
    logic [1:0]         bcnt_d, bcnt_q;
    logic [23:0]        asm_d, asm_q;
    logic               we;
    logic [INSTR_W-1:0] wword;
    logic [DW-1:0]      wdata;

    always_comb begin
        st_d    = st_q;
        ptr_d   = ptr_q;
        limit_d = limit_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we      = 1'b0;
        wword   = {ld_byte, asm_q};

        case (st_q)
            ST_IDLE: begin
                if (ld_start) begin
                    // Words past the end of memory are never written.
                    if (64'(ld_count) > 64'(DEPTH)) limit_d = CNT_W'(DEPTH);
                    else                            limit_d = ld_count;
                    ptr_d  = '0;
                    bcnt_d = 2'd0;
                    st_d   = (ld_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_byte_valid) begin
                    case (bcnt_q)
                        2'd0: asm_d[7:0]   = ld_byte;
                        2'd1: asm_d[15:8]  = ld_byte;
                        2'd2: asm_d[23:16] = ld_byte;
                        default: begin
                            we    = 1'b1;
                            ptr_d = ptr_q + CNT_W'(1);
                            if (ptr_d == limit_q) st_d = ST_DONE;
                        end
                    endcase
                    bcnt_d = bcnt_q + 2'd1;
                end
            end
            ST_DONE: st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase

        busy_d = (st_d != ST_IDLE);
        done_d = (st_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            ptr_q   <= '0;
            limit_q <= '0;
            bcnt_q  <= 2'd0;
            asm_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            ptr_q   <= ptr_d;
            limit_q <= limit_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ld_busy = busy_q;
    assign ld_done = done_q;

`ifdef IMEM_PARITY_EN
    assign wdata = {even_par(wword), wword};
`else
    assign wdata = wword;
`endif

    imem_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (AW'(ptr_q)),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (word_idx[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: loads, fetches, faults, resets mid-load.
module tb_imem_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        logic        par;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_ready, fetch_valid, fetch_fault;
    logic [31:0]       fetch_instr;
    logic              ld_start = 1'b0;
    logic [CNT_W-1:0]  ld_count = '0;
    logic              ld_byte_valid = 1'b0;
    logic [7:0]        ld_byte = '0;
    logic              ld_busy, ld_done;
`ifdef IMEM_PARITY_EN
    logic              par_err;
`endif

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .fetch_fault   (fetch_fault),
`ifdef IMEM_PARITY_EN
        .par_err       (par_err),
`endif
        .ld_start      (ld_start),
        .ld_count      (ld_count),
        .ld_byte_valid (ld_byte_valid),
        .ld_byte       (ld_byte),
        .ld_busy       (ld_busy),
        .ld_done       (ld_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fetch_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("fetch_instr", fetch_instr, e.instr);
                chk("fetch_fault", fetch_fault, e.fault);
`ifdef IMEM_PARITY_EN
                chk("par_err", par_err, e.par);
`endif
            end
        end
    end

    // Drive one fetch cycle; expectation is pushed only if the DUT can take it.
    task automatic fetch(input logic [31:0] addr, input logic par = 1'b0);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        if (fetch_ready) begin
            e.fault = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
            e.instr = e.fault ? NOP : ref_mem[addr[11:2]];
            e.par   = par;
            sb.push_back(e);
        end
        @(negedge clk);
        fetch_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_byte_valid = 1'b1;
        ld_byte       = b;
        @(negedge clk);
        ld_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic start_load(input int cnt);
        ld_start = 1'b1;
        ld_count = CNT_W'(cnt);
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_instr", fetch_instr, 0);
        chk("rst_busy", ld_busy, 0);
        chk("rst_done", ld_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", fetch_ready, 1);

        // Basic two-word load
        start_load(2);
        chk("ld_busy_on", ld_busy, 1);
        chk("ld_ready_off", fetch_ready, 0);
        send_word(32'h0000_0013);
        chk("ld_done_mid", ld_done, 0);
        send_word(32'h0010_0093);
        chk("ld_done_pulse", ld_done, 1);
        chk("ld_busy_done", ld_busy, 1);
        @(negedge clk);
        chk("ld_done_drop", ld_done, 0);
        chk("ld_busy_drop", ld_busy, 0);
        ref_mem[0] = 32'h0000_0013;
        ref_mem[1] = 32'h0010_0093;

        // Back-to-back fetches, including faults
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h2);
        fetch(32'h1000);
        fetch(32'h5);
        fetch(32'hFFFF_FFFC);
        fetch(32'h4);
        @(negedge clk);

        // Fetch and ld_start are both ignored during LOAD
        start_load(3);
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        chk("load_ready", fetch_ready, 0);
        send_word(32'hDEAD_BEEF);
        fetch_req = 1'b0;
        chk("load_no_valid", fetch_valid, 0);
        ld_start = 1'b1;
        ld_count = CNT_W'(1);
        @(negedge clk);
        ld_start = 1'b0;
        chk("restart_ignored", ld_busy, 1);
        send_word(32'h1234_5678);
        chk("restart_no_done", ld_done, 0);
        send_word(32'hCAFE_F00D);
        chk("ld3_done", ld_done, 1);
        @(negedge clk);
        ref_mem[0] = 32'hDEAD_BEEF;
        ref_mem[1] = 32'h1234_5678;
        ref_mem[2] = 32'hCAFE_F00D;
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);

        // Reset after 6 of 8 bytes
        start_load(2);
        send_word(32'h0BAD_F00D);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        #1;
        chk("mrst_busy", ld_busy, 0);
        chk("mrst_done", ld_done, 0);
        chk("mrst_ready", fetch_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_idle_busy", ld_busy, 0);
        ref_mem[0] = 32'h0BAD_F00D;
        fetch(32'h0);
        fetch(32'h4);
        // Partial word must not leak into the next load
        start_load(1);
        send_word(32'h7654_3210);
        chk("ld1_done", ld_done, 1);
        @(negedge clk);
        ref_mem[0] = 32'h7654_3210;
        fetch(32'h0);

        // Zero-length load
        start_load(0);
        chk("zero_done", ld_done, 1);
        chk("zero_busy", ld_busy, 1);
        @(negedge clk);
        chk("zero_done_drop", ld_done, 0);
        chk("zero_busy_drop", ld_busy, 0);
        fetch(32'h0);

        // ld_start coincident with a fetch returns pre-load data
        ld_start   = 1'b1;
        ld_count   = CNT_W'(1);
        fetch(32'h0);
        ld_start = 1'b0;
        send_word(32'hA5A5_5A5A);
        chk("coin_done", ld_done, 1);
        @(negedge clk);
        ref_mem[0] = 32'hA5A5_5A5A;
        fetch(32'h0);

        // Oversized load clamps at DEPTH words
        start_load(2000);
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            w = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
            ref_mem[i] = w;
            if (i == DEPTH - 1) chk("big_no_early_done", ld_done, 0);
            send_word(w);
        end
        chk("big_done", ld_done, 1);
        send_byte(8'h11);
        chk("big_busy_drop", ld_busy, 0);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("big_extra_ignored", ld_busy, 0);
        fetch(32'h0);
        fetch(32'h800);
        fetch(32'hFFC);
        fetch(32'h1000);

`ifdef IMEM_PARITY_EN
        dut.u_ram.mem_q[0][3] = ~dut.u_ram.mem_q[0][3];
        ref_mem[0] = ref_mem[0] ^ 32'h8;
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit instruction words (power of two).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning fetch byte-address width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning load word-count width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port fetch_req  input  1  fetch request.
REQ-007 SHALL have port fetch_addr  input  ADDR_W  fetch byte address.
REQ-008 SHALL have port fetch_ready  output  1  fetch can be accepted this cycle.
REQ-009 SHALL have port fetch_valid  output  1  fetch_instr/fetch_fault valid.
REQ-010 SHALL have port fetch_instr  output  32  fetched instruction.
REQ-011 SHALL have port fetch_fault  output  1  misaligned or out-of-range fetch.
REQ-012 SHALL have port ld_start  input  1  one-cycle pulse that starts a program load at word 0.
REQ-013 SHALL have port ld_count  input  CNT_W  number of words to load, sampled on ld_start.
REQ-014 SHALL have port ld_byte_valid  input  1  load byte strobe, e.g. from the UART RX.
REQ-015 SHALL have port ld_byte  input  8  load byte.
REQ-016 SHALL have port ld_busy  output  1  load in progress.
REQ-017 SHALL have port ld_done  output  1  one-cycle pulse when load completes.

Function
REQ-018 SHALL accept a fetch when fetch_req && fetch_ready; fetch_ready = !ld_busy.
REQ-019 SHALL assert fetch_valid exactly one cycle after acceptance (registered read, latency 1), for one cycle per request; back-to-back fetches SHALL be accepted every cycle.
REQ-020 SHALL, when fetch_addr[1:0] != 0 or fetch_addr[ADDR_W-1:2] >= DEPTH, return fetch_fault=1 and fetch_instr=32'h00000013 (NOP) with fetch_valid timing unchanged.
REQ-021 SHALL drive fetch_fault=0 and fetch_instr=mem[fetch_addr[ADDR_W-1:2]] for legal fetches.
REQ-022 SHALL ignore fetch_req while ld_busy=1, with no fetch_valid generated.
REQ-023 SHALL implement load FSM states IDLE, LOAD, DONE: IDLE->LOAD on ld_start; LOAD->DONE after the last word is written; DONE->IDLE after one cycle; ld_done=1 only in DONE; ld_busy=1 in LOAD and DONE.
REQ-024 SHALL, on ld_start with ld_count=0, go IDLE->DONE directly with no writes.
REQ-025 SHALL assemble 4 bytes little-endian (first byte -> [7:0]) via a 2-bit byte counter and write the word to mem[ld_ptr] on the 4th ld_byte_valid, then increment ld_ptr.
REQ-026 SHALL treat min(ld_count, DEPTH) as the word limit; bytes beyond it SHALL be ignored.
REQ-027 SHALL ignore ld_start while ld_busy=1, and ld_byte_valid outside LOAD.
REQ-028 SHALL, when ld_start and an accepted fetch coincide in IDLE, return pre-load memory contents for that fetch.

Reset
REQ-029 SHALL, on rst, asynchronously force fetch_valid=0, fetch_fault=0, fetch_instr=0, ld_busy=0, ld_done=0, FSM=IDLE, ld_ptr=0, byte counter=0.
REQ-030 SHALL discard a partially assembled word on rst mid-load; words already written and memory contents SHALL NOT be cleared.

Configuration
REQ-031 SHALL, with IMEM_PARITY_EN defined, store an even-parity bit per word at write time, add output port par_err (1 bit, reset 0) valid with fetch_valid, asserted on parity mismatch of a legal fetch.
REQ-032 SHALL, without IMEM_PARITY_EN, have no parity storage and no par_err port.

Structure
REQ-033 SHALL take the NOP constant, the FSM state enum and the instruction-width constant from shared package imem_pkg.
REQ-034 SHALL place the storage array and registered read in sub-module imem_ram (1 write port, 1 synchronous read port).

Verification
REQ-035 SHALL cover: rst, ld_start ld_count=2, bytes 13,00,00,00,93,00,10,00 -> two writes, ld_done one cycle; fetch 0x0 -> 0x00000013, fetch 0x4 -> 0x00100093.
REQ-036 SHALL cover: fetch_addr=0x2 -> fetch_fault=1, fetch_instr=0x00000013; fetch_addr=0x1000 with DEPTH=1024 -> fetch_fault=1.
REQ-037 SHALL cover: fetch_req during LOAD -> fetch_ready=0, no fetch_valid; ld_start during LOAD ignored.
REQ-038 SHALL cover: rst after 6 of 8 bytes -> word 0 kept, word 1 unchanged, FSM IDLE, ld_busy=0.
REQ-039 SHALL cover: ld_count=0 -> ld_done one cycle after ld_start, memory unchanged; ld_count=2000, DEPTH=1024 -> ld_done after 1024 words.
REQ-040 SHALL cover, with IMEM_PARITY_EN: forced bit flip in stored word 0, fetch 0x0 -> par_err=1.
